// File: rtl/frame_pkg.sv
// frame_pkg: shared display constants and types for the column scan path
package frame_pkg;
    localparam int SCAN_RATE = 32;
    localparam int NUM_ROWS  = 64;
    localparam int RGB_RES   = 9;
    localparam int COL_W     = $clog2(SCAN_RATE);
    typedef logic [2*NUM_ROWS*RGB_RES-1:0] column_pair_t;
    typedef enum logic [1:0] {CYLINDER, SPHERE, CUBE, BOIDS} display_mode_t;
    typedef enum logic [1:0] {IDLE, WAIT_SRC, PRESENT} sched_state_t;
endpackage

// File: rtl/slice_scheduler_if.sv
// slice_scheduler_if: presented column pair and valid/ready handshake towards the HUB75 driver
interface slice_scheduler_if;
    import frame_pkg::*;
    column_pair_t     columns;
    logic [COL_W-1:0] col_num1;
    logic [COL_W:0]   col_num2;
    logic             data_valid;
    logic             hub75_ready;
    modport master(output columns, col_num1, col_num2, data_valid, input hub75_ready);
    modport slave(input columns, col_num1, col_num2, data_valid, output hub75_ready);
endinterface

// File: rtl/theta_change_detect.sv
// theta_change_detect: flags a new rotor angle, or the forced first sweep after reset
module theta_change_detect #(
    parameter int W = 10
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic [W-1:0] dtheta,
    input  logic         load,
    output logic         change
);
    logic [W-1:0] last_theta;
    logic         force_sweep;

    assign change = force_sweep || (dtheta != last_theta);

    // remember the most recently accepted angle; the forced sweep is consumed by the first load
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_theta  <= '0;
            force_sweep <= 1'b1;
        end else if (load) begin
            last_theta  <= dtheta;
            force_sweep <= 1'b0;
        end
    end
endmodule

// File: rtl/slice_scheduler.sv
// slice_scheduler: theta-synchronous column-pair sequencer between frame sources and the HUB75 driver
module slice_scheduler
    import frame_pkg::*;
#(
    parameter int ROTATIONAL_RES = 1024,
    parameter int SRC_LATENCY    = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    input  logic [1:0]                        mode_req,
    input  column_pair_t                      src_columns,
    output display_mode_t                     mode,
    output logic [COL_W-1:0]                  col_index,
    output logic                              slice_done,
    output logic                              overrun,
    output logic                              busy,
    slice_scheduler_if.master                 hub
);
    localparam int CNT_W = $clog2(SRC_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRC_LATENCY - 1);

    sched_state_t     state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             pending, change, start, capture, advance, done_p, over_p, last_pair;

    // every change event is accepted at once: it either starts a sweep or marks one as stale
    theta_change_detect #(.W($clog2(ROTATIONAL_RES))) u_detect (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .dtheta   (dtheta),
        .load     (change),
        .change   (change)
    );

    assign busy      = state != IDLE;
    assign last_pair = col_index == COL_W'(SCAN_RATE - 1);
    // a change landing on the final handshake starts the next slice rather than aborting this one
    assign over_p    = busy && change && !done_p;

    // next state and the per-cycle control strobes
    always_comb begin
        state_d = state;
        start   = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        done_p  = 1'b0;
        case (state)
            IDLE: if (change) begin
                start   = 1'b1;
                state_d = WAIT_SRC;
            end
            WAIT_SRC: if (cnt == '0) begin
                capture = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: if (hub.hub75_ready) begin
                if (pending || change) begin
                    start   = 1'b1;
                    done_p  = !pending && last_pair;
                    state_d = WAIT_SRC;
                end else if (last_pair) begin
                    done_p  = 1'b1;
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = WAIT_SRC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else state <= state_d;
    end

    // sweep datapath: index, source latency counter, presented pair and pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode           <= CYLINDER;
            col_index      <= '0;
            cnt            <= '0;
            pending        <= 1'b0;
            slice_done     <= 1'b0;
            overrun        <= 1'b0;
            hub.columns    <= '0;
            hub.col_num1   <= '0;
            hub.col_num2   <= '0;
            hub.data_valid <= 1'b0;
        end else begin
            slice_done <= done_p;
            overrun    <= over_p;
            pending    <= !start && (pending || (busy && change));
            if (start) begin
                mode      <= display_mode_t'(mode_req);
                col_index <= '0;
                cnt       <= CNT_LOAD;
            end else if (advance) begin
                col_index <= col_index + 1'b1;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT_SRC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                hub.columns    <= src_columns;
                hub.col_num1   <= col_index;
                hub.col_num2   <= (COL_W+1)'(col_index) + (COL_W+1)'(SCAN_RATE);
                hub.data_valid <= 1'b1;
            end else if (state == PRESENT && hub.hub75_ready) begin
                hub.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_slice_scheduler.sv
// tb_slice_scheduler: scenario tasks against a timing-level reference of the scan protocol
module tb_slice_scheduler;
    import frame_pkg::*;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic [9:0]    dtheta = '0;
    logic [1:0]    mode_req = '0;
    column_pair_t  src_columns;
    display_mode_t mode;
    logic [4:0]    col_index;
    logic          slice_done, overrun, busy;
    logic [31:0]   salt = '0;
    int            cyc = 0;
    int            vectors = 0, miscompares = 0;

    slice_scheduler_if bus();

    slice_scheduler #(.ROTATIONAL_RES(1024), .SRC_LATENCY(2)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .dtheta      (dtheta),
        .mode_req    (mode_req),
        .src_columns (src_columns),
        .mode        (mode),
        .col_index   (col_index),
        .slice_done  (slice_done),
        .overrun     (overrun),
        .busy        (busy),
        .hub         (bus.master)
    );

    always #5 clk_in = ~clk_in;

    // edges since reset release; the edge that releases nothing counts as cycle 1
    always @(posedge clk_in or negedge rst_n_in) cyc <= rst_n_in ? cyc + 1 : 0;

    function automatic column_pair_t make_pair(input logic [4:0] i, input logic [31:0] s);
        logic [31:0] w;
        w = s ^ {27'd0, i};
        return {36{w}};
    endfunction

    // frame source: pair for the requested index becomes visible one edge after the index does
    always @(posedge clk_in) src_columns <= make_pair(col_index, salt);

    int hs_cyc[$], hs_idx[$], hs_n2[$], hs_mode[$], rise_cyc[$], done_q[$], ov_q[$];
    int data_err = 0, hold_err = 0;
    int busy_at[8192], idx_at[8192], mode_at[8192];
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [4:0] prev_n1 = '0;
    column_pair_t prev_cols = '0;

    // observer: samples 2ns after each falling edge, after the bench has driven its inputs
    always begin
        @(negedge clk_in);
        #2;
        if (rst_n_in) begin
            if (cyc < 8192) begin
                busy_at[cyc] = int'(busy);
                idx_at[cyc]  = int'(col_index);
                mode_at[cyc] = int'(mode);
            end
            if (prev_valid && !prev_ready &&
                (bus.data_valid !== 1'b1 || bus.columns !== prev_cols || bus.col_num1 !== prev_n1)) hold_err++;
            if (bus.data_valid && !prev_valid) rise_cyc.push_back(cyc);
            if (bus.data_valid && bus.hub75_ready) begin
                hs_cyc.push_back(cyc);
                hs_idx.push_back(int'(bus.col_num1));
                hs_n2.push_back(int'(bus.col_num2));
                hs_mode.push_back(int'(mode));
                if (bus.columns !== make_pair(bus.col_num1, salt)) data_err++;
            end
            if (slice_done) done_q.push_back(cyc);
            if (overrun) ov_q.push_back(cyc);
        end
        prev_valid = rst_n_in && bus.data_valid;
        prev_ready = bus.hub75_ready;
        prev_n1    = bus.col_num1;
        prev_cols  = bus.columns;
    end

    task automatic clear_log();
        hs_cyc.delete(); hs_idx.delete(); hs_n2.delete(); hs_mode.delete();
        rise_cyc.delete(); done_q.delete(); ov_q.delete();
        data_err = 0; hold_err = 0; prev_valid = 1'b0;
    endtask

    function automatic int seq_diff(input int got[$], input int exp[$]);
        int d;
        d = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
        for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] != exp[i]) d++;
        return d;
    endfunction

    task automatic wait_done(input int n, input int lim, output bit ok);
        int g = 0;
        while (done_q.size() < n && g < lim) begin
            @(negedge clk_in);
            #3;
            g++;
        end
        ok = done_q.size() >= n;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #1;
        vectors++; if ({slice_done, overrun, busy, bus.data_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {slice_done, overrun, busy, bus.data_valid}); end
        vectors++; if (col_index !== 5'd0) begin miscompares++; $display("FAIL reset_col_index: got %0d want 0", col_index); end
        vectors++; if (mode !== CYLINDER) begin miscompares++; $display("FAIL reset_mode: got %0d want 0", mode); end
        vectors++; if (bus.col_num1 !== 5'd0 || bus.col_num2 !== 6'd0) begin miscompares++; $display("FAIL reset_col_num: got %0d/%0d want 0/0", bus.col_num1, bus.col_num2); end
        vectors++; if (bus.columns !== '0) begin miscompares++; $display("FAIL reset_columns: got nonzero want 0"); end
    endtask

    task automatic test_first_sweep();
        int exp[$];
        bit ok;
        for (int i = 0; i < 32; i++) exp.push_back(i);
        repeat (3) @(negedge clk_in);
        clear_log(); salt = $urandom; dtheta = '0; bus.hub75_ready = 1'b1; rst_n_in = 1'b1;
        wait_done(1, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL first_sweep_timeout: got no slice_done want one within 300 cycles"); return; end
        vectors++; if (rise_cyc[0] != 3) begin miscompares++; $display("FAIL first_valid_cycle: got %0d want 3", rise_cyc[0]); end
        vectors++; if (hs_idx[0] != 0 || hs_n2[0] != 32) begin miscompares++; $display("FAIL first_col_nums: got %0d/%0d want 0/32", hs_idx[0], hs_n2[0]); end
        vectors++; if (seq_diff(hs_idx, exp) != 0) begin miscompares++; $display("FAIL first_sequence: got %0d deviations want 0", seq_diff(hs_idx, exp)); end
        vectors++; if (done_q[0] != 97) begin miscompares++; $display("FAIL first_done_cycle: got %0d want 97", done_q[0]); end
        vectors++; if (busy_at[97] != 0) begin miscompares++; $display("FAIL first_done_busy: got %0d want 0", busy_at[97]); end
        vectors++; if (data_err != 0) begin miscompares++; $display("FAIL first_data: got %0d bad pairs want 0", data_err); end
        repeat (20) @(negedge clk_in);
        #3;
        vectors++; if (hs_idx.size() != 32 || done_q.size() != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL first_no_resweep: got %0d pairs %0d dones busy %b want 32 1 0", hs_idx.size(), done_q.size(), busy); end
    endtask

    task automatic test_ready_stall();
        int exp[$];
        int guard = 0, stall = 0;
        for (int i = 0; i < 32; i++) exp.push_back(i);
        @(negedge clk_in);
        clear_log(); salt = $urandom; dtheta = 10'd5; bus.hub75_ready = 1'b1;
        while (done_q.size() == 0 && guard < 400) begin
            @(negedge clk_in);
            guard++;
            if (bus.data_valid && bus.col_num1 == 5'd5 && stall < 10) begin bus.hub75_ready = 1'b0; stall++; end
            else bus.hub75_ready = 1'b1;
        end
        #3;
        vectors++; if (done_q.size() == 0) begin miscompares++; $display("FAIL stall_timeout: got no slice_done want one within 400 cycles"); return; end
        vectors++; if (seq_diff(hs_idx, exp) != 0) begin miscompares++; $display("FAIL stall_sequence: got %0d deviations want 0", seq_diff(hs_idx, exp)); end
        vectors++; if (hs_cyc[5] - rise_cyc[5] != 10) begin miscompares++; $display("FAIL stall_hold_len: got %0d want 10", hs_cyc[5] - rise_cyc[5]); end
        vectors++; if (rise_cyc[6] != hs_cyc[5] + 3) begin miscompares++; $display("FAIL stall_next_pair: got %0d want %0d", rise_cyc[6], hs_cyc[5] + 3); end
        vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL stall_stability: got %0d changes want 0", hold_err); end
        vectors++; if (data_err != 0) begin miscompares++; $display("FAIL stall_data: got %0d bad pairs want 0", data_err); end
    endtask

    task automatic test_random_ready();
        bit rdy[512];
        int exp_h[$], exp_r[$], exp_i[$];
        int s, t, h, guard, bad;
        logic [1:0] m;
        for (int it = 0; it < 3; it++) begin
            foreach (rdy[j]) rdy[j] = (j >= 400) || ($urandom_range(0, 99) < 55);
            m = 2'($urandom_range(0, 3));
            exp_h.delete(); exp_r.delete(); exp_i.delete();
            @(negedge clk_in);
            clear_log(); salt = $urandom; mode_req = m;
            dtheta = dtheta + 10'($urandom_range(1, 50));
            s = cyc; bus.hub75_ready = rdy[0];
            t = s + 3;
            for (int i = 0; i < 32; i++) begin
                h = t;
                while (!rdy[h - s]) h++;
                exp_r.push_back(t); exp_h.push_back(h); exp_i.push_back(i);
                t = h + 3;
            end
            guard = 0;
            while (done_q.size() == 0 && guard < 600) begin
                @(negedge clk_in);
                guard++;
                bus.hub75_ready = (cyc - s < 512) ? rdy[cyc - s] : 1'b1;
            end
            #3;
            vectors++; if (done_q.size() == 0) begin miscompares++; $display("FAIL rand_timeout: iter %0d got no slice_done", it); continue; end
            vectors++; if (seq_diff(hs_cyc, exp_h) != 0) begin miscompares++; $display("FAIL rand_hs_timing: iter %0d got %0d deviations want 0", it, seq_diff(hs_cyc, exp_h)); end
            vectors++; if (seq_diff(rise_cyc, exp_r) != 0) begin miscompares++; $display("FAIL rand_valid_timing: iter %0d got %0d deviations want 0", it, seq_diff(rise_cyc, exp_r)); end
            vectors++; if (seq_diff(hs_idx, exp_i) != 0) begin miscompares++; $display("FAIL rand_sequence: iter %0d got %0d deviations want 0", it, seq_diff(hs_idx, exp_i)); end
            vectors++; if (done_q[0] != exp_h[31] + 1) begin miscompares++; $display("FAIL rand_done: iter %0d got %0d want %0d", it, done_q[0], exp_h[31] + 1); end
            bad = 0;
            foreach (hs_mode[j]) if (hs_mode[j] != int'(m)) bad++;
            vectors++; if (bad != 0) begin miscompares++; $display("FAIL rand_mode: iter %0d got %0d wrong want 0 (mode %0d)", it, bad, m); end
            vectors++; if (hold_err != 0 || data_err != 0) begin miscompares++; $display("FAIL rand_integrity: iter %0d got hold %0d data %0d want 0 0", it, hold_err, data_err); end
        end
    endtask

    task automatic test_overrun();
        int exp[$];
        int guard = 0, chg = 0;
        bit fired = 0;
        for (int i = 0; i <= 12; i++) exp.push_back(i);
        for (int i = 0; i < 32; i++) exp.push_back(i);
        @(negedge clk_in);
        clear_log(); salt = $urandom; dtheta = 10'd200; bus.hub75_ready = 1'b1;
        while (done_q.size() == 0 && guard < 400) begin
            @(negedge clk_in);
            guard++;
            if (!fired && busy && col_index == 5'd12) begin dtheta = 10'd201; fired = 1; chg = cyc; end
        end
        #3;
        vectors++; if (done_q.size() == 0) begin miscompares++; $display("FAIL overrun_timeout: got no slice_done want one within 400 cycles"); return; end
        vectors++; if (ov_q.size() != 1 || ov_q[0] != chg + 1) begin miscompares++; $display("FAIL overrun_pulse: got %0d pulses first at %0d want 1 at %0d", ov_q.size(), ov_q[0], chg + 1); end
        vectors++; if (seq_diff(hs_idx, exp) != 0) begin miscompares++; $display("FAIL overrun_sequence: got %0d deviations want 0", seq_diff(hs_idx, exp)); end
        vectors++; if (rise_cyc[13] != hs_cyc[12] + 3) begin miscompares++; $display("FAIL overrun_restart: got %0d want %0d", rise_cyc[13], hs_cyc[12] + 3); end
        vectors++; if (done_q.size() != 1 || done_q[0] != hs_cyc[44] + 1) begin miscompares++; $display("FAIL overrun_done: got %0d dones first at %0d want 1 at %0d", done_q.size(), done_q[0], hs_cyc[44] + 1); end
    endtask

    task automatic test_change_on_last();
        int exp[$];
        bit ok, fired = 0;
        int guard = 0, d;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) exp.push_back(i);
        @(negedge clk_in);
        clear_log(); salt = $urandom; dtheta = 10'd300; bus.hub75_ready = 1'b1;
        while (done_q.size() < 2 && guard < 400) begin
            @(negedge clk_in);
            guard++;
            if (!fired && bus.data_valid && bus.col_num1 == 5'd31) begin dtheta = 10'd301; fired = 1; end
        end
        #3;
        ok = done_q.size() >= 2;
        vectors++; if (!ok) begin miscompares++; $display("FAIL last_timeout: got %0d dones want 2", done_q.size()); return; end
        d = done_q[0];
        vectors++; if (d != hs_cyc[31] + 1) begin miscompares++; $display("FAIL last_done: got %0d want %0d", d, hs_cyc[31] + 1); end
        vectors++; if (ov_q.size() != 0) begin miscompares++; $display("FAIL last_overrun: got %0d pulses want 0", ov_q.size()); end
        vectors++; if (busy_at[d] != 1 || idx_at[d] != 0) begin miscompares++; $display("FAIL last_no_idle: got busy %0d idx %0d want 1 0", busy_at[d], idx_at[d]); end
        vectors++; if (rise_cyc[32] != hs_cyc[31] + 3) begin miscompares++; $display("FAIL last_next_valid: got %0d want %0d", rise_cyc[32], hs_cyc[31] + 3); end
        vectors++; if (seq_diff(hs_idx, exp) != 0 || done_q[1] != hs_cyc[63] + 1) begin miscompares++; $display("FAIL last_second_sweep: got %0d deviations done %0d want 0 %0d", seq_diff(hs_idx, exp), done_q[1], hs_cyc[63] + 1); end
    endtask

    task automatic test_mode();
        bit ok, fired = 0;
        int guard = 0, bad = 0;
        @(negedge clk_in);
        clear_log(); salt = $urandom; mode_req = 2'd1; dtheta = 10'd500; bus.hub75_ready = 1'b1;
        while (done_q.size() == 0 && guard < 400) begin
            @(negedge clk_in);
            guard++;
            if (!fired && col_index == 5'd8) begin mode_req = 2'd3; fired = 1; end
        end
        #3;
        vectors++; if (done_q.size() == 0) begin miscompares++; $display("FAIL mode_timeout: got no slice_done want one"); return; end
        foreach (hs_mode[j]) if (hs_mode[j] != 1) bad++;
        vectors++; if (bad != 0 || hs_mode.size() != 32) begin miscompares++; $display("FAIL mode_first_sweep: got %0d wrong of %0d want 0 of 32", bad, hs_mode.size()); end
        vectors++; if (mode !== SPHERE) begin miscompares++; $display("FAIL mode_after_sweep: got %0d want 1", mode); end
        @(negedge clk_in);
        clear_log(); dtheta = 10'd501;
        wait_done(1, 300, ok);
        bad = 0;
        foreach (hs_mode[j]) if (hs_mode[j] != 3) bad++;
        vectors++; if (!ok || bad != 0 || hs_mode.size() != 32) begin miscompares++; $display("FAIL mode_second_sweep: got %0d wrong of %0d done %0d want 0 of 32 done 1", bad, hs_mode.size(), ok); end
    endtask

    task automatic test_async_reset();
        int exp[$];
        int guard = 0;
        bit ok;
        for (int i = 0; i < 32; i++) exp.push_back(i);
        @(negedge clk_in);
        clear_log(); salt = $urandom; mode_req = 2'd2; dtheta = 10'd700; bus.hub75_ready = 1'b1;
        while (!(bus.data_valid && bus.col_num1 == 5'd5) && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        bus.hub75_ready = 1'b0;
        vectors++; if (!(bus.data_valid && bus.col_num1 == 5'd5)) begin miscompares++; $display("FAIL areset_setup: got valid %b num %0d want 1 5", bus.data_valid, bus.col_num1); end
        #3;
        rst_n_in = 1'b0;
        #1;
        vectors++; if ({slice_done, overrun, busy, bus.data_valid} !== 4'b0) begin miscompares++; $display("FAIL areset_flags: got %b want 0000", {slice_done, overrun, busy, bus.data_valid}); end
        vectors++; if (bus.col_num1 !== 5'd0 || bus.col_num2 !== 6'd0 || col_index !== 5'd0 || mode !== CYLINDER) begin miscompares++; $display("FAIL areset_fields: got %0d %0d %0d %0d want 0 0 0 0", bus.col_num1, bus.col_num2, col_index, mode); end
        vectors++; if (bus.columns !== '0) begin miscompares++; $display("FAIL areset_columns: got nonzero want 0"); end
        @(negedge clk_in);
        clear_log(); salt = $urandom; bus.hub75_ready = 1'b1; rst_n_in = 1'b1;
        wait_done(1, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL areset_timeout: got no slice_done want one"); return; end
        vectors++; if (rise_cyc[0] != 3 || seq_diff(hs_idx, exp) != 0) begin miscompares++; $display("FAIL areset_restart: got first valid %0d deviations %0d want 3 0", rise_cyc[0], seq_diff(hs_idx, exp)); end
        vectors++; if (done_q[0] != 97 || hs_mode[0] != 2 || data_err != 0) begin miscompares++; $display("FAIL areset_sweep: got done %0d mode %0d data %0d want 97 2 0", done_q[0], hs_mode[0], data_err); end
    endtask

    initial begin
        bus.hub75_ready = 1'b1;
        #2;
        test_reset();
        test_first_sweep();
        test_ready_stall();
        test_random_ready();
        test_overrun();
        test_change_on_last();
        test_mode();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by cycle %0d want finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/slice_scheduler.md
# slice_scheduler

Sequences the per-angle column scan for the rotating display. On each change of `dtheta` it walks the 32 column-pair indices and drives them into the frame source (sphere/cube/boids generators). It captures the returned column pairs after a fixed source latency and presents each pair to the HUB75 driver under a valid/ready handshake. It sits between the theta encoder, the frame sources and the HUB75 driver, and replaces the free-running column counter with a handshake-correct, theta-synchronous sequencer.

## Interface
Parameters:
- `ROTATIONAL_RES`, 1024: theta steps per revolution.
- `SCAN_RATE`, 32: column pairs per slice.
- `NUM_ROWS`, 64: LEDs per column.
- `RGB_RES`, 9: bits per pixel.
- `SRC_LATENCY`, 2: cycles from `col_index` change to valid `src_columns`. Must be ≥1.

Ports:
- `clk_in` in 1: system clock; the only clock.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `dtheta` in $clog2(ROTATIONAL_RES): current rotor angle.
- `mode_req` in 2: requested mode: 0 cylinder, 1 sphere, 2 cube, 3 boids.
- `src_columns` in 2×NUM_ROWS×RGB_RES: column pair from the frame source for `col_index`.
- `hub75_ready` in 1: driver accepts the presented pair.
- `mode` out 2: mode latched at sweep start, routed to the source mux.
- `col_index` out $clog2(SCAN_RATE): index requested from the source.
- `columns` out 2×NUM_ROWS×RGB_RES: presented pair.
- `col_num1` out $clog2(SCAN_RATE): first column number of the presented pair.
- `col_num2` out $clog2(SCAN_RATE)+1: second column number, always `col_num1`+SCAN_RATE.
- `data_valid` out 1: `columns`/`col_num*` valid.
- `slice_done` out 1: one-cycle pulse when the last pair of a sweep handshakes.
- `overrun` out 1: one-cycle pulse when theta changes mid-sweep.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Registered `last_theta`. A change event is `dtheta != last_theta`, or the `force` flag, which is set by reset and cleared at the first sweep start.
- States: IDLE, WAIT_SRC, PRESENT.
- IDLE, on a change event:
  - latch `last_theta`←`dtheta` and `mode`←`mode_req`;
  - set `col_index`←0 and the latency counter ←SRC_LATENCY−1;
  - go to WAIT_SRC.
- WAIT_SRC: decrement the counter. When it reaches 0:
  - capture `columns`←`src_columns`;
  - set `col_num1`←`col_index`, `col_num2`←`col_index`+SCAN_RATE (zero-extended, no wrap);
  - set `data_valid`←1 and go to PRESENT.
- PRESENT: hold all presented outputs stable until `hub75_ready`. `data_valid` is never retracted before the handshake. On the handshake `data_valid`←0, then:
  - if a theta change is pending: restart at `col_index`=0 with the new theta and a new `mode`, clear pending, go to WAIT_SRC;
  - else if `col_index`==SCAN_RATE−1: pulse `slice_done`, go to IDLE;
  - else: `col_index`+1, reload the counter, go to WAIT_SRC.
- Theta change while busy: pulse `overrun` once per change, set pending and update `last_theta`. The latest theta wins when changes repeat, and each change pulses `overrun`.
- A theta change on the same cycle as the last pair's handshake is treated as the start of a new slice:
  - `slice_done` pulses and `overrun` does not;
  - the state goes directly to WAIT_SRC with no IDLE cycle.
- `mode_req` is sampled only at sweep start. A mid-sweep mode change takes effect on the next sweep.

## Timing
- Reset values: all outputs 0; state IDLE; `force`=1, `pending`=0; `last_theta`=0.
- Reset asserted mid-sweep clears all state immediately, asynchronously. A fresh sweep of the current `dtheta` starts at the first edge after deassertion.
- `col_index` updates on edge E. `data_valid` rises on edge E+SRC_LATENCY.
- With `hub75_ready` held high, each pair takes SRC_LATENCY+1 cycles. A full sweep takes SCAN_RATE×(SRC_LATENCY+1) cycles: 96 at the defaults.
- `slice_done` is asserted in the cycle after the final handshake edge, together with `busy`=0.
- Change-to-`busy` latency is 1 cycle.

## Structure
- Package `frame_pkg`:
  - constants SCAN_RATE, NUM_ROWS, RGB_RES;
  - `column_pair_t` (2×NUM_ROWS×RGB_RES packed);
  - `display_mode_t` enum (CYLINDER, SPHERE, CUBE, BOIDS);
  - `sched_state_t` enum.
- One sub-module: `theta_change_detect`. It holds `last_theta` and `force`, outputs the change event, and takes a load strobe.

## Test plan
- Reset release with `dtheta`=0 and `hub75_ready`=1 -> sweep starts at once. First `data_valid` at cycle 3 with `col_num1`=0, `col_num2`=32. `slice_done` at cycle 97. No sweep follows while `dtheta` stays constant.
- `hub75_ready` low for 10 cycles while presenting pair 5 -> `columns`, `col_num1`=5 and `data_valid`=1 are held stable. Advance to pair 6 only after the ready cycle.
- `dtheta` 200→201 during pair 12 -> `overrun` pulses once. Pair 12 completes, then `col_index` restarts at 0 and `slice_done` is never asserted for the aborted sweep.
- `dtheta` change on the cycle of the pair-31 handshake -> `slice_done`=1, `overrun`=0, new sweep with `col_index`=0 and no IDLE cycle.
- `mode_req` 1→3 at pair 8 -> `mode` stays 1 until sweep end. The next sweep shows `mode`=3.
- `rst_n_in` low asynchronously during PRESENT -> all outputs 0 without a clock edge. Sweep restarts from 0 after release.
